// File: rtl/wddl_xorn_pipe.sv
// -----------------------------------------------------------------------------
// wddl_xorn_pipe
//
// Dual-rail (WDDL-style) N-input XOR with a one-stage registered output and an
// optional running XOR accumulator. Each operand bit is carried as a true rail
// (p) and a false rail (n). The interface alternates between two phases:
//   - evaluation: every pair is complementary (p = ~n)
//   - precharge:  every rail is 0
// Every evaluation cycle must be followed by at least one precharge cycle. The
// output pair follows the same discipline, so only 0/0 or p/~p ever appears on
// d_p_out/d_n_out.
//
// Handshake: valid_in=1 offers one beat for the current cycle; there is no
// back-pressure. A beat is accepted only when the phase FSM is in PRE and the
// rails are well formed. Its result appears exactly one cycle later with
// valid_out=1. Any cycle without an accepted beat produces a precharged 0/0
// output with valid_out=0 on the next cycle.
//
// Ports
//   clk_in         rising-edge clock
//   rstn_in        asynchronous, active-low reset
//   d_p_in         true rails, operand k at [k*WIDTH +: WIDTH]
//   d_n_in         false rails, same packing as d_p_in
//   valid_in       1 = evaluation beat, 0 = precharge cycle
//   acc_in         1 = XOR the beat result into the running accumulator
//   clr_in         zero the accumulator (used as base 0 on an accepted beat)
//   err_clr_in     clear the sticky error flags
//   d_p_out        registered true rails
//   d_n_out        registered false rails
//   valid_out      output pair is in evaluation
//   err_out        sticky flags: [0] rail encoding error, [1] protocol error
//   dbg_state_out  phase FSM state (0 = PRE, 1 = EVAL)
//   dbg_acc_out    internal single-rail accumulator
// -----------------------------------------------------------------------------
module wddl_xorn_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3
) (
    input  logic                     clk_in,
    input  logic                     rstn_in,
    input  logic [NUM_IN*WIDTH-1:0]  d_p_in,
    input  logic [NUM_IN*WIDTH-1:0]  d_n_in,
    input  logic                     valid_in,
    input  logic                     acc_in,
    input  logic                     clr_in,
    input  logic                     err_clr_in,
    output logic [WIDTH-1:0]         d_p_out,
    output logic [WIDTH-1:0]         d_n_out,
    output logic                     valid_out,
    output logic [1:0]               err_out,
    output logic                     dbg_state_out,
    output logic [WIDTH-1:0]         dbg_acc_out
);

    typedef enum logic {
        ST_PRE  = 1'b0,
        ST_EVAL = 1'b1
    } phase_t;

    phase_t             r_state;
    phase_t             w_state_nxt;

    logic [WIDTH-1:0]   r_d_p;
    logic [WIDTH-1:0]   r_d_n;
    logic               r_valid;
    logic [1:0]         r_err;
    logic [WIDTH-1:0]   r_acc;

    logic [WIDTH-1:0]   w_x;
    logic [WIDTH-1:0]   w_pair_bad;
    logic [WIDTH-1:0]   w_rail_hot;
    logic               w_enc_err;
    logic               w_proto_err;
    logic               w_accept;
    logic [WIDTH-1:0]   w_base;
    logic [WIDTH-1:0]   w_result;
    logic [1:0]         w_err_set;
    logic [1:0]         w_err_nxt;

    // XOR of the true rails plus per-bit encoding checks across all operands.
    // w_pair_bad marks bits where some operand has p == n (illegal while
    // evaluating); w_rail_hot marks bits where some rail is 1 (illegal while
    // precharging).
    always_comb begin
        w_x        = '0;
        w_pair_bad = '0;
        w_rail_hot = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_x        = w_x ^ d_p_in[k*WIDTH +: WIDTH];
            w_pair_bad = w_pair_bad |
                         ~(d_p_in[k*WIDTH +: WIDTH] ^ d_n_in[k*WIDTH +: WIDTH]);
            w_rail_hot = w_rail_hot |
                         d_p_in[k*WIDTH +: WIDTH] | d_n_in[k*WIDTH +: WIDTH];
        end
    end

    assign w_enc_err   = valid_in ? (|w_pair_bad) : (|w_rail_hot);

    // A beat arriving right after an evaluation skips the mandatory precharge.
    assign w_proto_err = valid_in && (r_state == ST_EVAL);

    assign w_accept    = valid_in && (r_state == ST_PRE) && !w_enc_err;

    // clr_in overrides acc_in: the beat starts a fresh accumulation from 0.
    assign w_base      = (clr_in || !acc_in) ? '0 : r_acc;
    assign w_result    = w_base ^ w_x;

    // Sticky flags: a set in the same cycle as a clear takes priority.
    assign w_err_set   = {w_proto_err, w_enc_err};
    assign w_err_nxt   = (err_clr_in ? 2'b00 : r_err) | w_err_set;

    // Phase FSM, next-state half. EVAL always returns to PRE so every
    // evaluation is followed by at least one precharge cycle.
    always_comb begin
        w_state_nxt = ST_PRE;
        case (r_state)
            ST_PRE:  w_state_nxt = w_accept ? ST_EVAL : ST_PRE;
            ST_EVAL: w_state_nxt = ST_PRE;
            default: w_state_nxt = ST_PRE;
        endcase
    end

    // Phase FSM, state register.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            r_state <= ST_PRE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output pair, accumulator and error flags.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            r_d_p   <= '0;
            r_d_n   <= '0;
            r_valid <= 1'b0;
            r_acc   <= '0;
            r_err   <= 2'b00;
        end else begin
            r_err <= w_err_nxt;
            if (w_accept) begin
                r_d_p   <= w_result;
                r_d_n   <= ~w_result;
                r_valid <= 1'b1;
                r_acc   <= w_result;
            end else begin
                // Dropped or absent beat: propagate precharge.
                r_d_p   <= '0;
                r_d_n   <= '0;
                r_valid <= 1'b0;
                if (clr_in) begin
                    r_acc <= '0;
                end
            end
        end
    end

    assign d_p_out       = r_d_p;
    assign d_n_out       = r_d_n;
    assign valid_out     = r_valid;
    assign err_out       = r_err;
    assign dbg_state_out = r_state;
    assign dbg_acc_out   = r_acc;

endmodule

// File: tb/tb_wddl_xorn_pipe.sv
// -----------------------------------------------------------------------------
// tb_wddl_xorn_pipe
//
// Self-checking bench for wddl_xorn_pipe (WIDTH=32, NUM_IN=3): a directed
// vector table with hand-computed expectations, a reset-during-evaluation
// sequence, and a randomized phase checked against a behavioural model.
// -----------------------------------------------------------------------------
module tb_wddl_xorn_pipe;

    localparam int W   = 32;
    localparam int N   = 3;
    localparam int NT  = 18;
    localparam int NRND = 400;

    logic             clk;
    logic             rstn;
    logic [N*W-1:0]   d_p_in;
    logic [N*W-1:0]   d_n_in;
    logic             valid_in;
    logic             acc_in;
    logic             clr_in;
    logic             err_clr_in;
    logic [W-1:0]     d_p_out;
    logic [W-1:0]     d_n_out;
    logic             valid_out;
    logic [1:0]       err_out;
    logic             dbg_state;
    logic [W-1:0]     dbg_acc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [N*W-1:0] p;
        logic [N*W-1:0] n;
        logic           valid;
        logic           acc;
        logic           clr;
        logic           eclr;
        logic [W-1:0]   exp_p;
        logic           exp_v;
        logic [1:0]     exp_err;
        logic [W-1:0]   exp_acc;
    } vec_t;

    vec_t tbl[NT];

    // Behavioural model state
    logic           m_eval;
    logic [W-1:0]   m_acc;
    logic [1:0]     m_err;

    wddl_xorn_pipe #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk_in        (clk),
        .rstn_in       (rstn),
        .d_p_in        (d_p_in),
        .d_n_in        (d_n_in),
        .valid_in      (valid_in),
        .acc_in        (acc_in),
        .clr_in        (clr_in),
        .err_clr_in    (err_clr_in),
        .d_p_out       (d_p_out),
        .d_n_out       (d_n_out),
        .valid_out     (valid_out),
        .err_out       (err_out),
        .dbg_state_out (dbg_state),
        .dbg_acc_out   (dbg_acc)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [N*W-1:0] pack3(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [W-1:0] c);
        return {c, b, a};
    endfunction

    function automatic vec_t mk(input logic [N*W-1:0] p, input logic [N*W-1:0] n,
                                input logic valid, input logic acc,
                                input logic clr, input logic eclr,
                                input logic [W-1:0] exp_p, input logic exp_v,
                                input logic [1:0] exp_err, input logic [W-1:0] exp_acc);
        vec_t v;
        v.p = p; v.n = n; v.valid = valid; v.acc = acc; v.clr = clr; v.eclr = eclr;
        v.exp_p = exp_p; v.exp_v = exp_v; v.exp_err = exp_err; v.exp_acc = exp_acc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [W-1:0] exp_p,
                           input logic exp_v, input logic [1:0] exp_err,
                           input logic [W-1:0] exp_acc);
        logic [W-1:0] exp_n;
        exp_n = exp_v ? ~exp_p : '0;
        chk({name, ".d_p"},  d_p_out, exp_p);
        chk({name, ".d_n"},  d_n_out, exp_n);
        chk({name, ".valid"}, {31'd0, valid_out}, {31'd0, exp_v});
        chk({name, ".err"},  {30'd0, err_out}, {30'd0, exp_err});
        chk({name, ".acc"},  dbg_acc, exp_acc);
    endtask

    // ---------------- driver ----------------
    // Inputs are changed 1 time unit after a rising edge; the task then
    // advances one edge and returns 1 unit later, ready for sampling.
    task automatic drive_step(input logic [N*W-1:0] p, input logic [N*W-1:0] n,
                              input logic valid, input logic acc,
                              input logic clr, input logic eclr);
        d_p_in = p; d_n_in = n; valid_in = valid;
        acc_in = acc; clr_in = clr; err_clr_in = eclr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        d_p_in = '0; d_n_in = '0; valid_in = 1'b0;
        acc_in = 1'b0; clr_in = 1'b0; err_clr_in = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        m_eval = 1'b0; m_acc = '0; m_err = 2'b00;
    endtask

    // ---------------- reference model ----------------
    // Checks every operand/bit against the phase's encoding rule, then applies
    // the accept / accumulate / sticky-error rules to one beat.
    task automatic model_step(input logic [N*W-1:0] p, input logic [N*W-1:0] n,
                              input logic valid, input logic acc,
                              input logic clr, input logic eclr,
                              output logic [W-1:0] exp_p, output logic exp_v);
        logic [W-1:0] x;
        logic [W-1:0] pk;
        logic [W-1:0] nk;
        logic         bad;
        logic         proto;
        logic         take;
        x = '0;
        bad = 1'b0;
        for (int k = 0; k < N; k++) begin
            pk = p[k*W +: W];
            nk = n[k*W +: W];
            x = x ^ pk;
            if (valid) begin
                if ((pk ^ nk) != '1) bad = 1'b1;
            end else begin
                if ((pk | nk) != '0) bad = 1'b1;
            end
        end
        proto = valid && m_eval;
        take  = valid && !m_eval && !bad;
        if (take) begin
            exp_p = (clr ? '0 : (acc ? m_acc : '0)) ^ x;
            exp_v = 1'b1;
            m_acc = exp_p;
        end else begin
            exp_p = '0;
            exp_v = 1'b0;
            if (clr) m_acc = '0;
        end
        m_eval = take;
        if (eclr) m_err = 2'b00;
        if (bad)   m_err[0] = 1'b1;
        if (proto) m_err[1] = 1'b1;
    endtask

    // ---------------- test ----------------
    initial begin
        logic [N*W-1:0] p;
        logic [N*W-1:0] n;
        logic [W-1:0]   ep;
        logic           ev;
        logic           rv, ra, rc, re;
        int             idx;

        // Directed table, applied from reset (acc=0, err=0, PRE).
        tbl[0]  = mk(pack3(32'h0000_00FF, 32'h0000_0F0F, 32'h1234_0000),
                     ~pack3(32'h0000_00FF, 32'h0000_0F0F, 32'h1234_0000),
                     1, 0, 0, 0, 32'h1234_0FF0, 1, 2'b00, 32'h1234_0FF0);
        tbl[1]  = mk('0, '0, 0, 0, 0, 0, 32'h0, 0, 2'b00, 32'h1234_0FF0);
        tbl[2]  = mk(pack3(32'h1, 32'h0, 32'h0), ~pack3(32'h1, 32'h0, 32'h0),
                     1, 0, 1, 0, 32'h1, 1, 2'b00, 32'h1);
        tbl[3]  = mk('0, '0, 0, 0, 0, 0, 32'h0, 0, 2'b00, 32'h1);
        tbl[4]  = mk(pack3(32'h3, 32'h0, 32'h0), ~pack3(32'h3, 32'h0, 32'h0),
                     1, 1, 0, 0, 32'h2, 1, 2'b00, 32'h2);
        tbl[5]  = mk('0, '0, 0, 0, 0, 0, 32'h0, 0, 2'b00, 32'h2);
        tbl[6]  = mk(pack3(32'h5, 32'h0, 32'h0), ~pack3(32'h5, 32'h0, 32'h0),
                     1, 0, 0, 0, 32'h5, 1, 2'b00, 32'h5);
        tbl[7]  = mk(pack3(32'h7, 32'h0, 32'h0), ~pack3(32'h7, 32'h0, 32'h0),
                     1, 0, 0, 0, 32'h0, 0, 2'b10, 32'h5);
        tbl[8]  = mk('0, '0, 0, 0, 0, 1, 32'h0, 0, 2'b00, 32'h5);
        p = pack3(32'h9, 32'h20, 32'h0);
        n = ~p;
        idx = W + 5;
        n[idx] = 1'b1;
        tbl[9]  = mk(p, n, 1, 1, 0, 0, 32'h0, 0, 2'b01, 32'h5);
        tbl[10] = mk('0, '0, 0, 0, 0, 1, 32'h0, 0, 2'b00, 32'h5);
        n = '0;
        n[0] = 1'b1;
        tbl[11] = mk('0, n, 0, 0, 0, 0, 32'h0, 0, 2'b01, 32'h5);
        tbl[12] = mk('0, '0, 0, 0, 0, 1, 32'h0, 0, 2'b00, 32'h5);
        tbl[13] = mk('0, n, 0, 0, 0, 1, 32'h0, 0, 2'b01, 32'h5);
        tbl[14] = mk('0, '0, 0, 0, 0, 1, 32'h0, 0, 2'b00, 32'h5);
        tbl[15] = mk('0, '0, 0, 0, 1, 0, 32'h0, 0, 2'b00, 32'h0);
        tbl[16] = mk(pack3(32'h6, 32'h0, 32'h0), ~pack3(32'h6, 32'h0, 32'h0),
                     1, 1, 0, 0, 32'h6, 1, 2'b00, 32'h6);
        tbl[17] = mk('0, '0, 0, 0, 0, 0, 32'h0, 0, 2'b00, 32'h6);

        idle_inputs();
        rstn = 1'b0;
        #1;
        chk_all("async_reset", 32'h0, 0, 2'b00, 32'h0);
        do_reset();
        chk_all("reset_state", 32'h0, 0, 2'b00, 32'h0);
        chk("reset_fsm", {31'd0, dbg_state}, 32'd0);

        for (int i = 0; i < NT; i++) begin
            drive_step(tbl[i].p, tbl[i].n, tbl[i].valid, tbl[i].acc,
                       tbl[i].clr, tbl[i].eclr);
            chk_all($sformatf("vec%0d", i), tbl[i].exp_p, tbl[i].exp_v,
                    tbl[i].exp_err, tbl[i].exp_acc);
        end

        // Reset asserted while the output is evaluating 0xFFFF_FFFF.
        do_reset();
        p = pack3(32'hFFFF_FFFF, 32'h0, 32'h0);
        drive_step(p, ~p, 1, 0, 0, 0);
        chk_all("pre_reset_eval", 32'hFFFF_FFFF, 1, 2'b00, 32'hFFFF_FFFF);
        rstn = 1'b0;
        #1;
        chk_all("reset_mid_eval", 32'h0, 0, 2'b00, 32'h0);
        // A clean beat presented across an edge while still in reset.
        p = pack3(32'hA5A5_0001, 32'h0, 32'h0);
        drive_step(p, ~p, 1, 0, 0, 0);
        chk_all("beat_during_reset", 32'h0, 0, 2'b00, 32'h0);
        rstn = 1'b1;
        drive_step(p, ~p, 1, 0, 0, 0);
        chk_all("first_beat_after_reset", 32'hA5A5_0001, 1, 2'b00, 32'hA5A5_0001);
        drive_step('0, '0, 0, 0, 0, 0);
        chk_all("precharge_after_reset", 32'h0, 0, 2'b00, 32'hA5A5_0001);

        // Randomized phase against the behavioural model.
        do_reset();
        for (int i = 0; i < NRND; i++) begin
            rv = ($urandom_range(0, 1) == 1);
            ra = ($urandom_range(0, 1) == 1);
            rc = ($urandom_range(0, 7) == 0);
            re = ($urandom_range(0, 3) == 0);
            if (rv) begin
                p = {$urandom, $urandom, $urandom};
                n = ~p;
                if ($urandom_range(0, 7) == 0) begin
                    idx = $urandom_range(0, N*W-1);
                    n[idx] = ~n[idx];
                end
            end else begin
                p = '0;
                n = '0;
                if ($urandom_range(0, 9) == 0) begin
                    idx = $urandom_range(0, N*W-1);
                    if ($urandom_range(0, 1) == 1) p[idx] = 1'b1;
                    else                           n[idx] = 1'b1;
                end
            end
            model_step(p, n, rv, ra, rc, re, ep, ev);
            drive_step(p, n, rv, ra, rc, re);
            chk_all($sformatf("rnd%0d", i), ep, ev, m_err, m_acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
